// File: rtl/mem_stage_if.sv
// Execute-side, data-memory and write-back signals of the memory stage.
// master = the stage itself, slave = its environment (execute, memory, write-back).
interface mem_stage_if #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
);
   logic               ex_valid;
   logic               ex_ready;
   logic [XLEN-1:0]    ex_alu_res;
   logic [XLEN-1:0]    ex_store_data;
   logic [RADDR_W-1:0] ex_rd_addr;
   logic               ex_rd_en;
   logic               ex_is_load;
   logic               ex_is_store;
   logic [2:0]         ex_funct3;

   // Memory request: mem_req_valid holds with stable fields until mem_req_ready;
   // the transfer happens on the clock edge where both are 1.
   logic               mem_req_valid;
   logic               mem_req_ready;
   logic [XLEN-1:0]    mem_addr;
   logic               mem_we;
   logic [XLEN-1:0]    mem_wdata;
   logic [3:0]         mem_wstrb;
   logic               mem_rsp_valid;
   logic [XLEN-1:0]    mem_rsp_rdata;

   logic [XLEN-1:0]    alu_res;
   logic               alu_res_en;
   logic [XLEN-1:0]    lsu_res;
   logic               lsu_res_en;
   logic [RADDR_W-1:0] rd_addr;
   logic               rd_en;
   logic               misalign;

   logic [1:0]         fsm_state;

   modport master (
      input  ex_valid, ex_alu_res, ex_store_data, ex_rd_addr, ex_rd_en,
             ex_is_load, ex_is_store, ex_funct3,
      output ex_ready,
      output mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      output alu_res, alu_res_en, lsu_res, lsu_res_en, rd_addr, rd_en, misalign,
      output fsm_state
   );

   modport slave (
      output ex_valid, ex_alu_res, ex_store_data, ex_rd_addr, ex_rd_en,
             ex_is_load, ex_is_store, ex_funct3,
      input  ex_ready,
      input  mem_req_valid, mem_addr, mem_we, mem_wdata, mem_wstrb,
      output mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
      input  alu_res, alu_res_en, lsu_res, lsu_res_en, rd_addr, rd_en, misalign,
      input  fsm_state
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access stage: passes ALU results through, runs load/store transactions on a
// word-wide data port and hands write-back registered one-cycle result pulses.
module mem_stage #(
   parameter int XLEN    = 32,
   parameter int RADDR_W = 5
) (
   input  logic       clk,
   input  logic       rst,
   mem_stage_if.master bus
);
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic               accept;
   logic               is_mem;
   logic               misaligned;
   logic [1:0]         ofs;
   logic [XLEN-1:0]    wdata_nxt;
   logic [3:0]         wstrb_nxt;

   logic [XLEN-3:0]    req_addr_hi;
   logic               req_we;
   logic [XLEN-1:0]    req_wdata;
   logic [3:0]         req_wstrb;
   logic [2:0]         cap_funct3;
   logic [1:0]         cap_ofs;
   logic [RADDR_W-1:0] cap_rd_addr;
   logic               cap_rd_en;

   logic [7:0]         ld_byte;
   logic [15:0]        ld_half;
   logic [XLEN-1:0]    ld_ext;

   assign accept = bus.ex_valid && (state == IDLE);

   // Decode of the instruction offered by execute: alignment and store lane placement.
   always_comb begin
      ofs        = bus.ex_alu_res[1:0];
      is_mem     = bus.ex_is_load || bus.ex_is_store;
      misaligned = ((bus.ex_funct3[1:0] == 2'b01) && ofs[0]) ||
                   ((bus.ex_funct3[1:0] == 2'b10) && (ofs != 2'b00));
      wdata_nxt  = bus.ex_store_data;
      wstrb_nxt  = 4'b1111;
      case (bus.ex_funct3[1:0])
         2'b00: begin
            wdata_nxt = {4{bus.ex_store_data[7:0]}};
            wstrb_nxt = 4'b0001 << ofs;
         end
         2'b01: begin
            wdata_nxt = {2{bus.ex_store_data[15:0]}};
            wstrb_nxt = 4'b0011 << ofs;
         end
         default: begin
            wdata_nxt = bus.ex_store_data;
            wstrb_nxt = 4'b1111;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt         = state;
      bus.ex_ready      = 1'b0;
      bus.mem_req_valid = 1'b0;
      bus.mem_addr      = {req_addr_hi, 2'b00};
      bus.mem_we        = req_we;
      bus.mem_wdata     = req_wdata;
      bus.mem_wstrb     = req_wstrb;
      bus.fsm_state     = state;
      case (state)
         IDLE: begin
            bus.ex_ready = 1'b1;
            if (accept && is_mem && !misaligned) state_nxt = REQ;
         end
         REQ: begin
            bus.mem_req_valid = 1'b1;
            if (bus.mem_req_ready) state_nxt = req_we ? IDLE : WAIT;
         end
         WAIT: begin
            if (bus.mem_rsp_valid) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         req_addr_hi <= '0;
         req_we      <= 1'b0;
         req_wdata   <= '0;
         req_wstrb   <= '0;
         cap_funct3  <= '0;
         cap_ofs     <= '0;
         cap_rd_addr <= '0;
         cap_rd_en   <= 1'b0;
      end else if (accept) begin
         req_addr_hi <= bus.ex_alu_res[XLEN-1:2];
         req_we      <= bus.ex_is_store;
         req_wdata   <= wdata_nxt;
         req_wstrb   <= wstrb_nxt;
         cap_funct3  <= bus.ex_funct3;
         cap_ofs     <= ofs;
         cap_rd_addr <= bus.ex_rd_addr;
         cap_rd_en   <= bus.ex_rd_en;
      end
   end

   always_comb begin
      ld_byte = bus.mem_rsp_rdata[7:0];
      case (cap_ofs)
         2'd1:    ld_byte = bus.mem_rsp_rdata[15:8];
         2'd2:    ld_byte = bus.mem_rsp_rdata[23:16];
         2'd3:    ld_byte = bus.mem_rsp_rdata[31:24];
         default: ld_byte = bus.mem_rsp_rdata[7:0];
      endcase
      ld_half = cap_ofs[1] ? bus.mem_rsp_rdata[31:16] : bus.mem_rsp_rdata[15:0];
      case (cap_funct3)
         3'b000:  ld_ext = {{(XLEN-8){ld_byte[7]}}, ld_byte};
         3'b100:  ld_ext = {{(XLEN-8){1'b0}}, ld_byte};
         3'b001:  ld_ext = {{(XLEN-16){ld_half[15]}}, ld_half};
         3'b101:  ld_ext = {{(XLEN-16){1'b0}}, ld_half};
         default: ld_ext = bus.mem_rsp_rdata;
      endcase
   end

   // Write-back pulses: everything clears each cycle unless a result is being retired.
   // A store completion is the all-zero pulse, so it needs no branch of its own.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         bus.alu_res    <= '0;
         bus.alu_res_en <= 1'b0;
         bus.lsu_res    <= '0;
         bus.lsu_res_en <= 1'b0;
         bus.rd_addr    <= '0;
         bus.rd_en      <= 1'b0;
         bus.misalign   <= 1'b0;
      end else begin
         bus.alu_res    <= '0;
         bus.alu_res_en <= 1'b0;
         bus.lsu_res    <= '0;
         bus.lsu_res_en <= 1'b0;
         bus.rd_addr    <= '0;
         bus.rd_en      <= 1'b0;
         bus.misalign   <= 1'b0;
         if (accept && !is_mem) begin
            bus.alu_res    <= bus.ex_alu_res;
            bus.alu_res_en <= 1'b1;
            bus.rd_addr    <= bus.ex_rd_addr;
            bus.rd_en      <= bus.ex_rd_en;
         end else if (accept && misaligned) begin
            bus.misalign   <= 1'b1;
         end else if ((state == WAIT) && bus.mem_rsp_valid) begin
            bus.lsu_res    <= ld_ext;
            bus.lsu_res_en <= 1'b1;
            bus.rd_addr    <= cap_rd_addr;
            bus.rd_en      <= cap_rd_en;
         end
      end
   end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: write-back pulses are scoreboarded against an
// expected queue, memory port behaviour is checked step by step.
module tb_mem_stage;
   localparam int XLEN    = 32;
   localparam int RADDR_W = 5;
   localparam int W       = 73;

   logic clk;
   logic rst;

   mem_stage_if #(.XLEN(XLEN), .RADDR_W(RADDR_W)) bus ();

   mem_stage #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic [W-1:0] exp_q[$];
   int n_cmp = 0;
   int n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] wb_vec(input logic [31:0] a, input logic ae,
                                          input logic [31:0] l, input logic le,
                                          input logic [4:0] rd, input logic re,
                                          input logic m);
      return {a, ae, l, le, rd, re, m};
   endfunction

   function automatic logic [W-1:0] obs_vec();
      return {bus.alu_res, bus.alu_res_en, bus.lsu_res, bus.lsu_res_en,
              bus.rd_addr, bus.rd_en, bus.misalign};
   endfunction

   // Scoreboard: every non-zero write-back cycle must match the head of the queue.
   always @(negedge clk) begin
      if (rst && (obs_vec() != '0)) begin
         if (exp_q.size() == 0) chk("wb_unexpected", obs_vec(), '0);
         else chk("wb_pulse", obs_vec(), exp_q.pop_front());
      end
   end

   task automatic drive_ex(input logic [31:0] a, input logic [31:0] sd, input logic [4:0] rd,
                           input logic re, input logic ld, input logic st, input logic [2:0] f3);
      bus.ex_valid      = 1'b1;
      bus.ex_alu_res    = a;
      bus.ex_store_data = sd;
      bus.ex_rd_addr    = rd;
      bus.ex_rd_en      = re;
      bus.ex_is_load    = ld;
      bus.ex_is_store   = st;
      bus.ex_funct3     = f3;
   endtask

   task automatic idle_ex();
      bus.ex_valid    = 1'b0;
      bus.ex_is_load  = 1'b0;
      bus.ex_is_store = 1'b0;
   endtask

   // Called just after a negedge; returns at the negedge where the result pulse is visible.
   task automatic mem_op(input string tag, input logic [31:0] a, input logic [2:0] f3,
                         input logic ld, input logic [31:0] sd, input logic [4:0] rd,
                         input int rdy_dly, input logic [31:0] rdata, input logic [31:0] exp_res,
                         input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb);
      logic [31:0] exp_addr;
      exp_addr = {a[31:2], 2'b00};
      drive_ex(a, sd, rd, 1'b1, ld, !ld, f3);
      if (ld) exp_q.push_back(wb_vec(32'h0, 1'b0, exp_res, 1'b1, rd, 1'b1, 1'b0));
      @(negedge clk);
      idle_ex();
      for (int i = 0; i <= rdy_dly; i++) begin
         chk({tag, "_req_valid"}, bus.mem_req_valid, 1);
         chk({tag, "_addr"}, bus.mem_addr, exp_addr);
         chk({tag, "_we"}, bus.mem_we, !ld);
         chk({tag, "_ex_ready_busy"}, bus.ex_ready, 0);
         if (!ld) begin
            chk({tag, "_wdata"}, bus.mem_wdata, exp_wdata);
            chk({tag, "_wstrb"}, bus.mem_wstrb, exp_wstrb);
         end
         if (i == rdy_dly) begin
            bus.mem_req_ready = 1'b1;
            if (ld) begin
               // response in the handshake cycle must be ignored
               bus.mem_rsp_valid = 1'b1;
               bus.mem_rsp_rdata = ~rdata;
            end
         end
         @(negedge clk);
      end
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      chk({tag, "_req_dropped"}, bus.mem_req_valid, 0);
      if (ld) begin
         chk({tag, "_ex_ready_wait"}, bus.ex_ready, 0);
         bus.mem_rsp_valid = 1'b1;
         bus.mem_rsp_rdata = rdata;
         @(negedge clk);
         bus.mem_rsp_valid = 1'b0;
         chk({tag, "_lsu_en"}, bus.lsu_res_en, 1);
      end else begin
         chk({tag, "_store_pulse"}, obs_vec(), '0);
      end
      chk({tag, "_ex_ready_done"}, bus.ex_ready, 1);
   endtask

   initial begin
      rst               = 1'b0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_rdata = '0;
      drive_ex(32'h0000_1234, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0, 3'b000);
      repeat (2) @(negedge clk);
      chk("rst_wb", obs_vec(), '0);
      chk("rst_ex_ready", bus.ex_ready, 1);
      chk("rst_req_valid", bus.mem_req_valid, 0);
      chk("rst_state", bus.fsm_state, 0);

      // ADD held valid through reset release: three back-to-back pulses
      rst = 1'b1;
      repeat (3) exp_q.push_back(wb_vec(32'h0000_1234, 1'b1, 32'h0, 1'b0, 5'd5, 1'b1, 1'b0));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("add_alu_en", bus.alu_res_en, 1);
         chk("add_ex_ready", bus.ex_ready, 1);
         if (i == 2) idle_ex();
      end
      @(negedge clk);
      chk("add_gap", obs_vec(), '0);

      drive_ex(32'hCAFE_0000, 32'h0, 5'd0, 1'b1, 1'b0, 1'b0, 3'b000);
      exp_q.push_back(wb_vec(32'hCAFE_0000, 1'b1, 32'h0, 1'b0, 5'd0, 1'b1, 1'b0));
      @(negedge clk);
      idle_ex();

      mem_op("lb",  32'h0000_1003, 3'b000, 1'b1, 32'h0, 5'd7,  2, 32'h8012_3456, 32'hFFFF_FF80, 32'h0, 4'h0);
      mem_op("lhu", 32'h0000_2002, 3'b101, 1'b1, 32'h0, 5'd8,  0, 32'hBEEF_0000, 32'h0000_BEEF, 32'h0, 4'h0);
      mem_op("lh",  32'h0000_3000, 3'b001, 1'b1, 32'h0, 5'd9,  1, 32'h1234_8001, 32'hFFFF_8001, 32'h0, 4'h0);
      mem_op("lbu", 32'h0000_3001, 3'b100, 1'b1, 32'h0, 5'd10, 0, 32'h0000_F100, 32'h0000_00F1, 32'h0, 4'h0);
      mem_op("lw",  32'h0000_4004, 3'b010, 1'b1, 32'h0, 5'd11, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0, 4'h0);
      mem_op("sb",  32'h0000_0012, 3'b000, 1'b0, 32'h0000_00A5, 5'd12, 1, 32'h0, 32'h0, 32'hA5A5_A5A5, 4'b0100);
      mem_op("sh",  32'h0000_0022, 3'b001, 1'b0, 32'h1234_BEEF, 5'd13, 0, 32'h0, 32'h0, 32'hBEEF_BEEF, 4'b1100);
      mem_op("sw",  32'h0000_0030, 3'b010, 1'b0, 32'h0102_0304, 5'd14, 0, 32'h0, 32'h0, 32'h0102_0304, 4'b1111);

      // Misaligned word load and halfword store
      drive_ex(32'h0000_0006, 32'h0, 5'd15, 1'b1, 1'b1, 1'b0, 3'b010);
      exp_q.push_back(wb_vec(32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1));
      @(negedge clk);
      idle_ex();
      chk("mis_lw_req_valid", bus.mem_req_valid, 0);
      chk("mis_lw_flag", bus.misalign, 1);
      chk("mis_lw_ex_ready", bus.ex_ready, 1);
      drive_ex(32'h0000_0005, 32'h1111_2222, 5'd16, 1'b1, 1'b0, 1'b1, 3'b001);
      exp_q.push_back(wb_vec(32'h0, 1'b0, 32'h0, 1'b0, 5'd0, 1'b0, 1'b1));
      @(negedge clk);
      idle_ex();
      chk("mis_sh_req_valid", bus.mem_req_valid, 0);
      @(negedge clk);
      chk("mis_after_req_valid", bus.mem_req_valid, 0);
      chk("mis_after_wb", obs_vec(), '0);

      // Reset while in REQ: request must drop without waiting for a clock
      drive_ex(32'h0000_0040, 32'h5555_5555, 5'd17, 1'b1, 1'b0, 1'b1, 3'b010);
      @(negedge clk);
      idle_ex();
      chk("rreq_req_valid", bus.mem_req_valid, 1);
      rst = 1'b0;
      #1;
      chk("rreq_req_async", bus.mem_req_valid, 0);
      chk("rreq_ex_ready", bus.ex_ready, 1);
      @(negedge clk);
      rst = 1'b1;

      // Reset while in WAIT, then a stale response
      drive_ex(32'h0000_0050, 32'h0, 5'd18, 1'b1, 1'b1, 1'b0, 3'b010);
      @(negedge clk);
      idle_ex();
      bus.mem_req_ready = 1'b1;
      @(negedge clk);
      bus.mem_req_ready = 1'b0;
      chk("rwait_in_wait", bus.fsm_state, 2);
      rst = 1'b0;
      #1;
      chk("rwait_ex_ready", bus.ex_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_rdata = 32'h5555_5555;
      @(negedge clk);
      bus.mem_rsp_valid = 1'b0;
      chk("rwait_no_pulse", obs_vec(), '0);
      chk("rwait_idle", bus.ex_ready, 1);

      drive_ex(32'h0000_0077, 32'h0, 5'd3, 1'b1, 1'b0, 1'b0, 3'b000);
      exp_q.push_back(wb_vec(32'h0000_0077, 1'b1, 32'h0, 1'b0, 5'd3, 1'b1, 1'b0));
      @(negedge clk);
      idle_ex();
      chk("post_reset_add", bus.alu_res_en, 1);

      repeat (3) @(negedge clk);
      chk("drain", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
